// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-side types used by the cache/physical-memory arbiter.
package cache_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;
    typedef lc3b_word     lc3b_pmem_addr;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } lc3b_arb_side;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one physical memory port.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_pmem_read,
    input  lc3b_pmem_addr i_pmem_address,
    output lc3b_mem_data  i_pmem_rdata,
    output logic          i_pmem_resp,

    input  logic          d_pmem_read,
    input  logic          d_pmem_write,
    input  lc3b_pmem_addr d_pmem_address,
    input  lc3b_mem_data  d_pmem_wdata,
    output lc3b_mem_data  d_pmem_rdata,
    output logic          d_pmem_resp,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_pmem_addr pmem_address,
    output lc3b_mem_data  pmem_wdata,
    input  lc3b_mem_data  pmem_rdata,
    input  logic          pmem_resp
);

    lc3b_arb_state state;
    lc3b_arb_side  last_grant;
    lc3b_pmem_addr addr_q;
    lc3b_mem_data  wdata_q;
    logic          wr_q;

    logic i_req;
    logic d_req;
    logic pick_d;

    always_comb begin
        i_req  = i_pmem_read;
        d_req  = d_pmem_read | d_pmem_write;
        pick_d = d_req;
        if (i_req && d_req)
            pick_d = RR_ENABLE ? (last_grant == SIDE_I) : 1'b1;
    end

    // pmem_read/pmem_write are flops set on grant and cleared on resp, which
    // matches decoding GRANT_I | (GRANT_D & ~wr_q) from the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SIDE_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        if (pick_d) begin
                            state      <= GRANT_D;
                            last_grant <= SIDE_D;
                            addr_q     <= d_pmem_address;
                            wdata_q    <= d_pmem_wdata;
                            wr_q       <= d_pmem_write;
                            pmem_read  <= ~d_pmem_write;
                            pmem_write <= d_pmem_write;
                        end else begin
                            state      <= GRANT_I;
                            last_grant <= SIDE_I;
                            addr_q     <= i_pmem_address;
                            wr_q       <= 1'b0;
                            pmem_read  <= 1'b1;
                            pmem_write <= 1'b0;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = (state == GRANT_I) & pmem_resp;
    assign d_pmem_resp  = (state == GRANT_D) & pmem_resp;

    // Read data is unqualified; caches only consume it alongside their resp.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));

endmodule
